// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the seven-segment scan controller.
// Segment patterns are stored active-high as {g,f,e,d,c,b,a}. The board polarity
// is applied only at the output registers.
package seg7_pkg;

  // Bit positions within the 8-bit segment bus {dp,g,f,e,d,c,b,a}.
  localparam int unsigned SegA  = 0;
  localparam int unsigned SegB  = 1;
  localparam int unsigned SegC  = 2;
  localparam int unsigned SegD  = 3;
  localparam int unsigned SegE  = 4;
  localparam int unsigned SegF  = 5;
  localparam int unsigned SegG  = 6;
  localparam int unsigned SegDp = 7;

  localparam int unsigned FontEntries = 16;
  localparam int unsigned FontWidth   = 7;

  // Hex font, indexed by nibble value. Entry 15 is listed first because this is
  // a packed concatenation.
  localparam logic [FontEntries-1:0][FontWidth-1:0] Font = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  // Converts an active-high bus to the board's electrical polarity.
  function automatic logic [7:0] apply_polarity(input logic [7:0] value,
                                                input bit         active_low);
    return active_low ? ~value : value;
  endfunction

endpackage

// File: rtl/seg7_font_rom.sv
// Combinational hex-to-seven-segment decoder. The output is active-high {g,f,e,d,c,b,a}.
module seg7_font_rom
  import seg7_pkg::*;
(
  input  logic [3:0]           nibble,
  output logic [FontWidth-1:0] pattern
);

  // Pure table lookup. All 16 codes are defined, so no default is needed.
  always_comb begin
    pattern = Font[nibble];
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit seven-segment scan controller.
// An internal prescaler divides each digit slot into a blanking window and a lit window.
// A sequencer steps through the digits. Loaded values are staged and copied to the
// display register only at a frame boundary, so a scan never mixes two values.
// Optional build macro: SEG7_LEADING_ZERO_SUPPRESS_EN blanks leading zero digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,      // 1..8
  parameter int unsigned PRESCALE     = 50000,  // clocks per digit slot, >= 2
  parameter int unsigned BLANK_CYCLES = 500,    // anti-ghost window, < PRESCALE
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast  = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0] CntBlank = CntW'(BLANK_CYCLES);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

  // "Everything dark" in board polarity. The reset value of the output registers.
  localparam logic [7:0]            SegIdle    = apply_polarity(8'h00, ACTIVE_LOW);
  localparam logic [7:0]            AnIdleWide = apply_polarity(8'h00, ACTIVE_LOW);
  localparam logic [NUM_DIGITS-1:0] AnIdle     = AnIdleWide[NUM_DIGITS-1:0];

  // Prescaler and sequencer.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            slot_end;
  logic            frame_end;

  // Staging (written by load) and display (changed only at frame boundaries).
  logic [4*NUM_DIGITS-1:0] stage_digits_q, stage_digits_d;
  logic [NUM_DIGITS-1:0]   stage_dp_q, stage_dp_d;
  logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d;
  logic                    pending_q, pending_d;
  logic [4*NUM_DIGITS-1:0] disp_digits_q, disp_digits_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  // Selected-digit datapath.
  logic [3:0]            sel_nibble;
  logic                  sel_dp;
  logic                  sel_blank;
  logic                  sel_suppress;
  logic [NUM_DIGITS-1:0] suppress;
  logic [FontWidth-1:0]  font_pattern;
  logic [7:0]            seg_raw;
  logic [7:0]            an_raw;
  logic [7:0]            an_pol;

  // Output registers.
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_tick_q;

  assign slot_end  = (cnt_q == CntLast);
  assign frame_end = slot_end && (idx_q == IdxLast);

  // Prescaler wraps every PRESCALE clocks. The digit index steps on each wrap.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end
  end

  // Load staging. A load that lands on the boundary itself bypasses the stage.
  always_comb begin
    stage_digits_d = stage_digits_q;
    stage_dp_d     = stage_dp_q;
    stage_blank_d  = stage_blank_q;
    pending_d      = pending_q;
    disp_digits_d  = disp_digits_q;
    disp_dp_d      = disp_dp_q;
    disp_blank_d   = disp_blank_q;
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        disp_digits_d = digits_in;
        disp_dp_d     = dp_in;
        disp_blank_d  = blank_in;
      end else if (pending_q) begin
        disp_digits_d = stage_digits_q;
        disp_dp_d     = stage_dp_q;
        disp_blank_d  = stage_blank_q;
      end
    end else if (load) begin
      stage_digits_d = digits_in;
      stage_dp_d     = dp_in;
      stage_blank_d  = blank_in;
      pending_d      = 1'b1;
    end
  end

`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
  // Walk down from the most significant digit. Blank it while it is a bare zero.
  // Digit 0 is never considered, so a value of zero still shows one '0'.
  always_comb begin
    logic run;
    run      = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (run && (disp_digits_q[4*i +: 4] == 4'h0) && !disp_dp_q[i]) begin
        suppress[i] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end
`else
  assign suppress = '0;
`endif

  // Mux the current digit's fields out of the display register.
  always_comb begin
    sel_nibble   = 4'h0;
    sel_dp       = 1'b0;
    sel_blank    = 1'b0;
    sel_suppress = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        sel_nibble   = disp_digits_q[4*i +: 4];
        sel_dp       = disp_dp_q[i];
        sel_blank    = disp_blank_q[i];
        sel_suppress = suppress[i];
      end
    end
  end

  seg7_font_rom u_font_rom (
    .nibble  (sel_nibble),
    .pattern (font_pattern)
  );

  // Segment and anode patterns for the next output register load.
  // The segment bus keeps the selected digit's pattern during blanking. Only the
  // anodes go dark.
  always_comb begin
    seg_raw        = '0;
    seg_raw[SegDp] = sel_dp;
    seg_raw[SegG:SegA] = font_pattern;
    if (sel_blank || sel_suppress) begin
      seg_raw = '0;
    end
    an_raw = '0;
    if (cnt_q >= CntBlank) begin
      an_raw[idx_q] = 1'b1;
    end
    seg_d  = apply_polarity(seg_raw, ACTIVE_LOW);
    an_pol = apply_polarity(an_raw, ACTIVE_LOW);
    an_d   = an_pol[NUM_DIGITS-1:0];
  end

  // All state. A reset aborts the slot in progress and drops any staged load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      idx_q          <= '0;
      stage_digits_q <= '0;
      stage_dp_q     <= '0;
      stage_blank_q  <= '0;
      pending_q      <= 1'b0;
      disp_digits_q  <= '0;
      disp_dp_q      <= '0;
      disp_blank_q   <= '0;
      seg_q          <= SegIdle;
      an_q           <= AnIdle;
      frame_tick_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      stage_digits_q <= stage_digits_d;
      stage_dp_q     <= stage_dp_d;
      stage_blank_q  <= stage_blank_d;
      pending_q      <= pending_d;
      disp_digits_q  <= disp_digits_d;
      disp_dp_q      <= disp_dp_d;
      disp_blank_q   <= disp_blank_d;
      seg_q          <= seg_d;
      an_q           <= an_d;
      frame_tick_q   <= frame_end;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (4 digits, 4-clock slots, 1 blank clock, active-low).
// The reference model tracks elapsed cycles since reset. It derives slot and digit
// positions arithmetically and applies the frame-boundary load rules to a
// shown/staged pair.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int PS    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * PS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .PRESCALE     (PS),
    .BLANK_CYCLES (BC),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .load       (load),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          t;                     // cycles since reset release
  logic [15:0] m_dig, s_dig;          // shown / staged values
  logic [3:0]  m_dp, m_bl, s_dp, s_bl;
  bit          m_pend;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_ft;

  // Returns the pin value for digit d of the shown value.
  function automatic logic [7:0] glyph(input int d);
    int         lead;
    bit         stop;
    logic [6:0] f;
    logic [7:0] g;
    lead = 0;
    stop = 0;
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
    for (int k = ND - 1; k >= 1; k--) begin
      if (!stop && m_dig[4*k +: 4] == 4'h0 && !m_dp[k]) lead++;
      else stop = 1;
    end
`endif
    f = font_tab[m_dig[4*d +: 4]];
    g = {m_dp[d], f};
    if (m_bl[d] || d >= ND - lead) g = 8'h00;
    return ~g;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      t      <= 0;
      m_pend <= 0;
      m_dig  <= '0; m_dp <= '0; m_bl <= '0;
      s_dig  <= '0; s_dp <= '0; s_bl <= '0;
      e_seg  <= 8'hFF;
      e_an   <= 4'hF;
      e_ft   <= 1'b0;
    end else begin
      e_ft  <= ((t % FRAME) == FRAME - 1);
      e_an  <= ((t % PS) >= BC) ? ~(4'b0001 << ((t / PS) % ND)) : 4'hF;
      e_seg <= glyph((t / PS) % ND);
      if ((t % FRAME) == FRAME - 1) begin
        m_pend <= 0;
        if (load) begin
          m_dig <= digits_in; m_dp <= dp_in; m_bl <= blank_in;
        end else if (m_pend) begin
          m_dig <= s_dig; m_dp <= s_dp; m_bl <= s_bl;
        end
      end else if (load) begin
        s_dig <= digits_in; s_dp <= dp_in; s_bl <= blank_in;
        m_pend <= 1;
      end
      t <= t + 1;
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (seg !== 8'hFF || an !== 4'hF || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: seg=%h an=%h tick=%b, expected FF F 0", seg, an, frame_tick);
      end
    end
    rst = 1'b0;
    // First post-release output reflects cnt=0, which is a blanking clock.
    @(negedge clk);
    checks++;
    if (an !== 4'hF || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_blank: an=%h tick=%b, expected F 0", an, frame_tick);
    end
    @(negedge clk);
    checks++;
    if (an !== 4'hE || seg !== 8'hC0) begin
      errors++;
      $display("FAIL reset_first_anode: an=%h seg=%h, expected E C0", an, seg);
    end
  endtask

  task automatic test_scan();
    logic [7:0] want [4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};  // '4','3','2','1'
    int lit [4] = '{default: 0};
    int n = 0;
    int last_ft = 0;
    @(negedge clk);
    digits_in = 16'h1234; dp_in = '0; blank_in = '0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL scan_wait_tick: tick=%b after %0d cycles, expected 1", frame_tick, n);
    end
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg || an !== e_an || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL scan_model: seg=%h an=%h tick=%b, expected %h %h %b",
                 seg, an, frame_tick, e_seg, e_an, e_ft);
      end
      if (frame_tick === 1'b1) begin
        checks++;
        if (c - last_ft != FRAME) begin
          errors++;
          $display("FAIL scan_tick_period: gap=%0d, expected %0d", c - last_ft, FRAME);
        end
        last_ft = c;
      end
      for (int d = 0; d < ND; d++) begin
        if (an === ~(4'b0001 << d)) begin
          lit[d]++;
          checks++;
          if (seg !== want[d]) begin
            errors++;
            $display("FAIL scan_digit%0d: seg=%h, expected %h", d, seg, want[d]);
          end
        end
      end
    end
    for (int d = 0; d < ND; d++) begin
      checks++;
      if (lit[d] != 2 * (PS - BC)) begin
        errors++;
        $display("FAIL scan_lit_count%0d: %0d, expected %0d", d, lit[d], 2 * (PS - BC));
      end
    end
  endtask

  // Entered on the negedge where frame_tick is high, i.e. at the start of a frame.
  task automatic test_tear_free();
    logic [7:0] want;
    for (int c = 1; c <= 3 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg || an !== e_an || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL tear_model: seg=%h an=%h tick=%b, expected %h %h %b",
                 seg, an, frame_tick, e_seg, e_an, e_ft);
      end
      want = (c <= FRAME) ? 8'h99 : (c <= 2 * FRAME) ? 8'hA1 : 8'h92;  // '4','d','5'
      if (an === 4'hE) begin
        checks++;
        if (seg !== want) begin
          errors++;
          $display("FAIL tear_digit0 c=%0d: seg=%h, expected %h", c, seg, want);
        end
      end
      if (c % FRAME == 0) begin
        checks++;
        if (frame_tick !== 1'b1) begin
          errors++;
          $display("FAIL tear_tick c=%0d: tick=%b, expected 1", c, frame_tick);
        end
      end
      load = 1'b0;
      if (c == 5)  begin digits_in = 16'hABCD; load = 1'b1; end
      if (c == 21) begin digits_in = 16'h1111; load = 1'b1; end
      if (c == 25) begin digits_in = 16'h5555; load = 1'b1; end
    end
    load = 1'b0;
  endtask

  task automatic test_boundary_load();
    int n = 0;
    while ((t % FRAME) != FRAME - 1 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    digits_in = 16'h00F0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL boundary_tick: tick=%b, expected 1", frame_tick);
    end
    // Two frames: the second catches a stale staged value leaking in.
    for (int c = 1; c <= 2 * FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg || an !== e_an || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL boundary_model: seg=%h an=%h tick=%b, expected %h %h %b",
                 seg, an, frame_tick, e_seg, e_an, e_ft);
      end
      if (an === 4'hD) begin
        checks++;
        if (seg !== 8'h8E) begin
          errors++;
          $display("FAIL boundary_digit1 c=%0d: seg=%h, expected 8E", c, seg);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    int n = 0;
    @(negedge clk);
    digits_in = 16'h1234; dp_in = 4'b0001; blank_in = 4'b0100; load = 1'b1;
    @(negedge clk);
    load = 1'b0; dp_in = '0; blank_in = '0;
    while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    for (int c = 1; c <= FRAME; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg || an !== e_an || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL blank_model: seg=%h an=%h tick=%b, expected %h %h %b",
                 seg, an, frame_tick, e_seg, e_an, e_ft);
      end
      if (an === 4'hB) begin
        checks++;
        if (seg !== 8'hFF) begin
          errors++;
          $display("FAIL blank_digit2: seg=%h, expected FF", seg);
        end
      end
      if (an === 4'hE) begin
        checks++;
        if (seg !== 8'h19) begin
          errors++;
          $display("FAIL dp_digit0: seg=%h, expected 19", seg);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [7:0] want [4];
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      digits_in = (pass == 0) ? 16'h0070 : 16'h0000;
      dp_in = '0; blank_in = '0; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
`ifdef SEG7_LEADING_ZERO_SUPPRESS_EN
      want = (pass == 0) ? '{8'hC0, 8'hF8, 8'hFF, 8'hFF} : '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
`else
      want = (pass == 0) ? '{8'hC0, 8'hF8, 8'hC0, 8'hC0} : '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
      n = 0;
      while (frame_tick !== 1'b1 && n < 3 * FRAME) begin
        @(negedge clk);
        n++;
      end
      for (int c = 1; c <= FRAME; c++) begin
        @(negedge clk);
        for (int d = 0; d < ND; d++) begin
          if (an === ~(4'b0001 << d)) begin
            checks++;
            if (seg !== want[d] || seg !== e_seg) begin
              errors++;
              $display("FAIL lzs_p%0d_digit%0d: seg=%h, expected %h (model %h)",
                       pass, d, seg, want[d], e_seg);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_midscan();
    @(negedge clk);
    digits_in = 16'h8888; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (seg !== 8'hFF || an !== 4'hF || frame_tick !== 1'b0) begin
        errors++;
        $display("FAIL midscan_reset: seg=%h an=%h tick=%b, expected FF F 0", seg, an, frame_tick);
      end
    end
    rst = 1'b0;
    for (int c = 1; c <= 2 * FRAME + 2; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg || an !== e_an || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL midscan_model: seg=%h an=%h tick=%b, expected %h %h %b",
                 seg, an, frame_tick, e_seg, e_an, e_ft);
      end
      if (an === 4'h7) begin
        checks++;
        if (seg !== 8'hC0 && seg !== 8'hFF) begin
          errors++;
          $display("FAIL midscan_discard: seg=%h, expected cleared digit", seg);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== e_seg || an !== e_an || frame_tick !== e_ft) begin
        errors++;
        $display("FAIL random_model c=%0d: seg=%h an=%h tick=%b, expected %h %h %b",
                 c, seg, an, frame_tick, e_seg, e_an, e_ft);
      end
      load = ($urandom_range(0, 5) == 0);
      digits_in = 16'($urandom);
      dp_in     = 4'($urandom);
      blank_in  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tear_free();
    test_boundary_load();
    test_blank_dp();
    test_leading_zero();
    test_reset_midscan();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
